// File: rtl/receive_if.sv
// RMII receive-side bus: PHY dibit inputs plus the opponent-state outputs.
// Signalling: there is no ready. eth_crsdv qualifies eth_rxd on every eth_clk
// rising edge, and the receiver must take the dibit in that cycle. The
// frame_valid/chk_err outputs are single-cycle strobes with no acknowledge.
// opp_* are only meaningful as a set and change together on one edge.
interface receive_if;
    logic        eth_crsdv;
    logic [1:0]  eth_rxd;
    logic [10:0] opp_x;
    logic [10:0] opp_y;
    logic [8:0]  opp_dir;
    logic [2:0]  opp_stat;
    logic        frame_valid;
    logic        chk_err;

    // PHY / stimulus side
    modport master (
        output eth_crsdv, eth_rxd,
        input  opp_x, opp_y, opp_dir, opp_stat, frame_valid, chk_err
    );

    // Receiver side
    modport slave (
        input  eth_crsdv, eth_rxd,
        output opp_x, opp_y, opp_dir, opp_stat, frame_valid, chk_err
    );
endinterface

// File: rtl/receive.sv
// RMII receive stage. Hunts preamble + SFD, deserialises a fixed payload
// followed by an XOR checksum byte, and latches opponent kart state atomically
// when the checksum matches.
module receive #(
    parameter int MIN_PREAMBLE  = 8,
    parameter int PAYLOAD_BYTES = 5
) (
    input  logic        eth_clk,
    input  logic        eth_rst_n,
    receive_if.slave    rx,
    output logic [2:0]  dbg_state_o
);
    localparam int FRAME_DIBITS = 4 * (PAYLOAD_BYTES + 1);
    localparam int SR_W         = 8 * (PAYLOAD_BYTES + 1);
    localparam int DIB_W        = $clog2(FRAME_DIBITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        pre_cnt_q, pre_cnt_d;
    logic [DIB_W-1:0]  dib_cnt_q, dib_cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [10:0]       opp_x_q, opp_x_d;
    logic [10:0]       opp_y_q, opp_y_d;
    logic [8:0]        opp_dir_q, opp_dir_d;
    logic [2:0]        opp_stat_q, opp_stat_d;
    logic              frame_valid_q, frame_valid_d;
    logic              chk_err_q, chk_err_d;
    logic [7:0]        xsum;
    logic              chk_ok;

    // XOR of the payload bytes compared with the trailing checksum byte
    always_comb begin
        xsum = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            xsum = xsum ^ sr_q[8*i +: 8];
        end
        chk_ok = (xsum == sr_q[8*PAYLOAD_BYTES +: 8]);
    end

    // Next-state, counters, shift register and output loads
    always_comb begin
        state_d       = state_q;
        pre_cnt_d     = pre_cnt_q;
        dib_cnt_d     = dib_cnt_q;
        sr_d          = sr_q;
        opp_x_d       = opp_x_q;
        opp_y_d       = opp_y_q;
        opp_dir_d     = opp_dir_q;
        opp_stat_d    = opp_stat_q;
        frame_valid_d = 1'b0;
        chk_err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx.eth_crsdv) begin
                    if (rx.eth_rxd == 2'b01) begin
                        state_d   = S_PRE;
                        pre_cnt_d = 5'd1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_PRE: begin
                if (!rx.eth_crsdv) begin
                    state_d = S_IDLE;
                end else if (rx.eth_rxd == 2'b01) begin
                    if (pre_cnt_q != 5'd31) pre_cnt_d = pre_cnt_q + 5'd1;
                end else if (rx.eth_rxd == 2'b11 && pre_cnt_q >= 5'(MIN_PREAMBLE)) begin
                    state_d   = S_DATA;
                    dib_cnt_d = '0;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DATA: begin
                if (!rx.eth_crsdv) begin
                    // Carrier lost: discard the partial frame silently
                    state_d = S_IDLE;
                end else begin
                    // LSB-first wire order: newest dibit enters at the top
                    sr_d      = {rx.eth_rxd, sr_q[SR_W-1:2]};
                    dib_cnt_d = dib_cnt_q + DIB_W'(1);
                    if (dib_cnt_q == DIB_W'(FRAME_DIBITS - 1)) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (chk_ok) begin
                    opp_x_d       = sr_q[10:0];
                    opp_y_d       = sr_q[21:11];
                    opp_dir_d     = sr_q[30:22];
                    opp_stat_d    = sr_q[33:31];
                    frame_valid_d = 1'b1;
                end else begin
                    chk_err_d = 1'b1;
                end
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!rx.eth_crsdv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q       <= S_IDLE;
            pre_cnt_q     <= '0;
            dib_cnt_q     <= '0;
            sr_q          <= '0;
            opp_x_q       <= '0;
            opp_y_q       <= '0;
            opp_dir_q     <= '0;
            opp_stat_q    <= '0;
            frame_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            dib_cnt_q     <= dib_cnt_d;
            sr_q          <= sr_d;
            opp_x_q       <= opp_x_d;
            opp_y_q       <= opp_y_d;
            opp_dir_q     <= opp_dir_d;
            opp_stat_q    <= opp_stat_d;
            frame_valid_q <= frame_valid_d;
            chk_err_q     <= chk_err_d;
        end
    end

    assign rx.opp_x       = opp_x_q;
    assign rx.opp_y       = opp_y_q;
    assign rx.opp_dir     = opp_dir_q;
    assign rx.opp_stat    = opp_stat_q;
    assign rx.frame_valid = frame_valid_q;
    assign rx.chk_err     = chk_err_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_receive.sv
// Bench for the RMII receive stage: directed frames followed by random ones,
// checked against a frame-level model of what the receiver should report.
module tb_receive;
    localparam int MIN_PRE = 8;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;
    receive_if  bus ();

    receive #(.MIN_PREAMBLE(MIN_PRE), .PAYLOAD_BYTES(5)) dut (
        .eth_clk     (clk),
        .eth_rst_n   (rst_n),
        .rx          (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [33:0] m_fields = '0;     // model of {stat, dir, y, x}
    logic [33:0] exp_q[$];
    logic [1:0]  tx_q[$];
    logic [2:0]  seen_fv;
    logic [2:0]  seen_ce;

    function automatic logic [33:0] pack(input int x, input int y, input int d, input int s);
        return {3'(s), 9'(d), 11'(y), 11'(x)};
    endfunction

    function automatic logic [33:0] observed();
        return {bus.opp_stat, bus.opp_dir, bus.opp_y, bus.opp_x};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame image as dibits: n01 preamble dibits, SFD dibit, payload, checksum
    task automatic build_frame(input int n01, input logic [33:0] fields,
                               input logic [5:0] pad, input logic [7:0] chk_flip);
        logic [39:0] w;
        logic [7:0]  b;
        logic [7:0]  ck;
        w  = {pad, fields};
        ck = 8'h00;
        tx_q.delete();
        for (int i = 0; i < n01; i++) tx_q.push_back(2'b01);
        tx_q.push_back(2'b11);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                b  = w[8*i +: 8];
                ck = ck ^ b;
            end else begin
                b = ck ^ chk_flip;
            end
            for (int k = 0; k < 4; k++) tx_q.push_back(b[2*k +: 2]);
        end
    endtask

    // Drive n_send dibits, then watch three cycles while trailing/idle
    task automatic send(input int n_send, input int n_trail);
        for (int i = 0; i < n_send; i++) begin
            @(negedge clk);
            bus.eth_crsdv = 1'b1;
            bus.eth_rxd   = tx_q[i];
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen_fv[k] = bus.frame_valid;
            seen_ce[k] = bus.chk_err;
            if (k < n_trail) begin
                bus.eth_crsdv = 1'b1;
                bus.eth_rxd   = 2'($urandom_range(0, 3));
            end else begin
                bus.eth_crsdv = 1'b0;
                bus.eth_rxd   = 2'b00;
            end
        end
        repeat (2) begin
            @(negedge clk);
            bus.eth_crsdv = 1'b0;
        end
    endtask

    // One frame end to end: model decides the outcome from the frame's shape
    task automatic run_frame(input string tag, input int n01, input logic [33:0] fields,
                             input logic [5:0] pad, input logic [7:0] chk_flip,
                             input int n_pay, input int n_trail);
        logic       accepted;
        logic [2:0] exp_fv;
        logic [2:0] exp_ce;
        build_frame(n01, fields, pad, chk_flip);
        send(n01 + 1 + n_pay, n_trail);
        accepted = (n01 >= MIN_PRE) && (n_pay == 24);
        exp_fv   = (accepted && chk_flip == 8'h00) ? 3'b010 : 3'b000;
        exp_ce   = (accepted && chk_flip != 8'h00) ? 3'b010 : 3'b000;
        if (exp_fv != 3'b000) m_fields = fields;
        exp_q.push_back(m_fields);
        check({tag, ".fv"}, 64'(seen_fv), 64'(exp_fv));
        check({tag, ".ce"}, 64'(seen_ce), 64'(exp_ce));
        check({tag, ".opp"}, 64'(observed()), 64'(exp_q.pop_front()));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [33:0] t2;
        logic [33:0] t4;
        t2 = pack(8, 8, 90, 1);
        t4 = pack(1023, 767, 0, 2);
        bus.eth_crsdv = 1'b0;
        bus.eth_rxd   = 2'b00;
        rst_n         = 1'b0;

        // 1: reset held with carrier toggling
        repeat (6) begin
            @(negedge clk);
            bus.eth_crsdv = 1'($urandom_range(0, 1));
            bus.eth_rxd   = 2'($urandom_range(0, 3));
        end
        check("rst.opp", 64'(observed()), 64'(0));
        check("rst.pulses", 64'({bus.frame_valid, bus.chk_err}), 64'(0));
        check("rst.state", 64'(dbg_state), 64'(0));
        @(negedge clk);
        bus.eth_crsdv = 1'b0;
        rst_n         = 1'b1;
        repeat (5) @(negedge clk);
        check("idle.opp", 64'(observed()), 64'(0));
        check("idle.pulses", 64'({bus.frame_valid, bus.chk_err}), 64'(0));

        // 2: good frame (7x55, D5, 08 40 80 96 00 5E)
        run_frame("good", 31, t2, 6'd0, 8'h00, 24, 0);
        // 3: same frame, checksum 5F
        run_frame("badck", 31, t2, 6'd0, 8'h01, 24, 0);
        // 4: carrier dropped after payload byte 2, then a good frame
        run_frame("abort", 31, t4, 6'd0, 8'h00, 12, 0);
        run_frame("after_abort", 31, t4, 6'd0, 8'h00, 24, 2);
        // 5: preamble one dibit short of the minimum, then exactly the minimum
        run_frame("short_pre", MIN_PRE - 1, t2, 6'd0, 8'h00, 24, 0);
        run_frame("min_pre", MIN_PRE, t2, 6'd0, 8'h00, 24, 3);
        run_frame("sat_pre", 40, t4, 6'h3F, 8'h00, 24, 1);

        // 6: reset pulsed during payload byte 3
        build_frame(31, t2, 6'd0, 8'h00);
        for (int i = 0; i < 31 + 1 + 14; i++) begin
            @(negedge clk);
            bus.eth_crsdv = 1'b1;
            bus.eth_rxd   = tx_q[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_fields = '0;
        check("midrst.opp", 64'(observed()), 64'(m_fields));
        check("midrst.pulses", 64'({bus.frame_valid, bus.chk_err}), 64'(0));
        @(negedge clk);
        bus.eth_crsdv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("postrst.opp", 64'(observed()), 64'(m_fields));
        run_frame("after_rst", 31, t2, 6'd0, 8'h00, 24, 0);

        // Random frames: preamble length, fields, pad, checksum, truncation
        for (int n = 0; n < 40; n++) begin
            int          n01;
            int          n_pay;
            logic [7:0]  flip;
            logic [33:0] f;
            n01   = $urandom_range(4, 36);
            n_pay = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 23) : 24;
            flip  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            f     = pack($urandom_range(0, 2047), $urandom_range(0, 2047),
                         $urandom_range(0, 511), $urandom_range(0, 7));
            run_frame($sformatf("rnd%0d", n), n01, f, 6'($urandom_range(0, 63)),
                      flip, n_pay, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the whole run
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
